// File: rtl/struct_frame_accum.sv
// struct_frame_accum
//   Consumes a valid/ready stream of 4-bit struct_t words ({hi[1:0], lo[1:0]}) through a
//   2-entry input FIFO, sums the hi and lo fields over frames of FRAME_LEN words with
//   saturation, and presents one registered result per frame on a valid/ready output.
//
// Ports:
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   in_valid/in_ready     input handshake; in_data is the struct_t word
//   out_valid/out_ready   result handshake
//   out_hi_sum/out_lo_sum per-field frame sums (saturating at 2^SUM_W-1)
//   out_sat               a sum saturated during the reported frame
module struct_frame_accum #(
   parameter int unsigned FRAME_LEN = 4,
   parameter int unsigned SUM_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SUM_W-1:0] out_hi_sum,
   output logic [SUM_W-1:0] out_lo_sum,
   output logic             out_sat
);

   typedef enum logic [0:0] {StAccum, StHold} state_e;

   localparam logic [SUM_W-1:0] SumMax  = '1;
   localparam logic [7:0]       LastCnt = 8'(FRAME_LEN - 1);

   state_e           state_q, state_d;
   logic             resume_q, resume_d;

   logic [3:0]       fifo_mem_q [2];
   logic             wr_ptr_q, rd_ptr_q;
   logic [1:0]       fifo_cnt_q;
   logic             push, pop;
   logic [3:0]       pop_word;

   logic [SUM_W-1:0] hi_acc_q, hi_acc_d;
   logic [SUM_W-1:0] lo_acc_q, lo_acc_d;
   logic             sat_acc_q, sat_acc_d;
   logic [7:0]       cnt_q, cnt_d;

   logic [SUM_W-1:0] out_hi_q, out_hi_d;
   logic [SUM_W-1:0] out_lo_q, out_lo_d;
   logic             out_sat_q, out_sat_d;

   logic [SUM_W:0]   hi_add, lo_add;
   logic [SUM_W-1:0] hi_next, lo_next;
   logic             sat_next, frame_done;

   // in_ready only looks at the registered fill level; a same-cycle pop does not free a slot.
   assign in_ready = rst_n && (fifo_cnt_q != 2'd2);
   assign push     = in_valid && in_ready;
   // The first ACCUM cycle after a result handshake is a resume cycle without a pop.
   assign pop      = (state_q == StAccum) && !resume_q && (fifo_cnt_q != 2'd0);
   assign pop_word = fifo_mem_q[rd_ptr_q];

   // One extra bit catches the carry that signals saturation.
   assign hi_add     = {1'b0, hi_acc_q} + {{(SUM_W-1){1'b0}}, pop_word[3:2]};
   assign lo_add     = {1'b0, lo_acc_q} + {{(SUM_W-1){1'b0}}, pop_word[1:0]};
   assign hi_next    = hi_add[SUM_W] ? SumMax : hi_add[SUM_W-1:0];
   assign lo_next    = lo_add[SUM_W] ? SumMax : lo_add[SUM_W-1:0];
   assign sat_next   = sat_acc_q | hi_add[SUM_W] | lo_add[SUM_W];
   assign frame_done = pop && (cnt_q == LastCnt);

   assign out_valid  = (state_q == StHold);
   assign out_hi_sum = out_hi_q;
   assign out_lo_sum = out_lo_q;
   assign out_sat    = out_sat_q;

   // Input FIFO: two registered entries, no bypass.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_mem_q[0] <= 4'd0;
         fifo_mem_q[1] <= 4'd0;
         wr_ptr_q      <= 1'b0;
         rd_ptr_q      <= 1'b0;
         fifo_cnt_q    <= 2'd0;
      end else begin
         if (push) begin
            fifo_mem_q[wr_ptr_q] <= in_data;
            wr_ptr_q             <= !wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= !rd_ptr_q;
         end
         if (push && !pop) begin
            fifo_cnt_q <= fifo_cnt_q + 2'd1;
         end else if (!push && pop) begin
            fifo_cnt_q <= fifo_cnt_q - 2'd1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      resume_d  = 1'b0;
      hi_acc_d  = hi_acc_q;
      lo_acc_d  = lo_acc_q;
      sat_acc_d = sat_acc_q;
      cnt_d     = cnt_q;
      out_hi_d  = out_hi_q;
      out_lo_d  = out_lo_q;
      out_sat_d = out_sat_q;
      unique case (state_q)
         StAccum: begin
            if (pop) begin
               if (frame_done) begin
                  out_hi_d  = hi_next;
                  out_lo_d  = lo_next;
                  out_sat_d = sat_next;
                  hi_acc_d  = '0;
                  lo_acc_d  = '0;
                  sat_acc_d = 1'b0;
                  cnt_d     = 8'd0;
                  state_d   = StHold;
               end else begin
                  hi_acc_d  = hi_next;
                  lo_acc_d  = lo_next;
                  sat_acc_d = sat_next;
                  cnt_d     = cnt_q + 8'd1;
               end
            end
         end
         StHold: begin
            if (out_ready) begin
               state_d  = StAccum;
               resume_d = 1'b1;
            end
         end
         default: state_d = StAccum;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StAccum;
         resume_q  <= 1'b0;
         hi_acc_q  <= '0;
         lo_acc_q  <= '0;
         sat_acc_q <= 1'b0;
         cnt_q     <= 8'd0;
         out_hi_q  <= '0;
         out_lo_q  <= '0;
         out_sat_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         resume_q  <= resume_d;
         hi_acc_q  <= hi_acc_d;
         lo_acc_q  <= lo_acc_d;
         sat_acc_q <= sat_acc_d;
         cnt_q     <= cnt_d;
         out_hi_q  <= out_hi_d;
         out_lo_q  <= out_lo_d;
         out_sat_q <= out_sat_d;
      end
   end

endmodule

// File: tb/tb_struct_frame_accum.sv
// Directed bench for struct_frame_accum: three instances (default, SUM_W=3, FRAME_LEN=1).
module tb_struct_frame_accum;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance a: FRAME_LEN=4, SUM_W=8
   logic       a_rst_n, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_sat;
   logic [3:0] a_in_data;
   logic [7:0] a_out_hi_sum, a_out_lo_sum;
   // Instance b: FRAME_LEN=4, SUM_W=3
   logic       b_rst_n, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_sat;
   logic [3:0] b_in_data;
   logic [2:0] b_out_hi_sum, b_out_lo_sum;
   // Instance c: FRAME_LEN=1, SUM_W=8
   logic       c_rst_n, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_sat;
   logic [3:0] c_in_data;
   logic [7:0] c_out_hi_sum, c_out_lo_sum;

   int checks = 0;
   int passed = 0;
   int a_pushed = 0, a_target = 0, b_pushed = 0, b_target = 0;
   int n, extra;

   struct_frame_accum #(.FRAME_LEN(4), .SUM_W(8)) u_a (
      .clk(clk), .rst_n(a_rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_hi_sum(a_out_hi_sum), .out_lo_sum(a_out_lo_sum), .out_sat(a_out_sat)
   );
   struct_frame_accum #(.FRAME_LEN(4), .SUM_W(3)) u_b (
      .clk(clk), .rst_n(b_rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_hi_sum(b_out_hi_sum), .out_lo_sum(b_out_lo_sum), .out_sat(b_out_sat)
   );
   struct_frame_accum #(.FRAME_LEN(1), .SUM_W(8)) u_c (
      .clk(clk), .rst_n(c_rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
      .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
      .out_hi_sum(c_out_hi_sum), .out_lo_sum(c_out_lo_sum), .out_sat(c_out_sat)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One clock: count accepted words, advance, then drop valid once the target is reached.
   task automatic tick();
      if (a_in_valid && a_in_ready) a_pushed++;
      if (b_in_valid && b_in_ready) b_pushed++;
      @(posedge clk);
      #1;
      if (a_pushed == a_target) a_in_valid = 1'b0;
      if (b_pushed == b_target) b_in_valid = 1'b0;
   endtask

   initial begin
      a_rst_n = 1'b0; b_rst_n = 1'b0; c_rst_n = 1'b0;
      a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
      a_in_data = 4'h0; b_in_data = 4'h0; c_in_data = 4'h0;
      a_out_ready = 1'b0; b_out_ready = 1'b0; c_out_ready = 1'b0;
      #1;
      tick();
      tick();
      // Reset state
      check("rst in_ready", a_in_ready, 1'b0);
      check("rst out_valid", a_out_valid, 1'b0);
      check("rst hi_sum", a_out_hi_sum, 8'd0);
      check("rst lo_sum", a_out_lo_sum, 8'd0);
      a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;
      #1;
      check("post-rst in_ready", a_in_ready, 1'b1);

      // T1: 4 back-to-back 4'h5 words; result in cycle 5 for one cycle
      a_pushed = 0; a_target = 4; a_in_data = 4'h5; a_in_valid = 1'b1; a_out_ready = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         tick();
         check($sformatf("t1 out_valid c%0d", c), a_out_valid, (c == 5));
         if (c == 5) begin
            check("t1 hi_sum", a_out_hi_sum, 8'd4);
            check("t1 lo_sum", a_out_lo_sum, 8'd4);
            check("t1 sat", a_out_sat, 1'b0);
         end
      end

      // T2: SUM_W=3, 4 words of 4'hF saturate at 7; then a frame of zeros
      b_pushed = 0; b_target = 4; b_in_data = 4'hF; b_in_valid = 1'b1; b_out_ready = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!b_out_valid && n < 20);
      check("t2 valid", b_out_valid, 1'b1);
      check("t2 hi_sum sat", b_out_hi_sum, 3'd7);
      check("t2 lo_sum sat", b_out_lo_sum, 3'd7);
      check("t2 sat", b_out_sat, 1'b1);
      b_pushed = 0; b_target = 4; b_in_data = 4'h0; b_in_valid = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!b_out_valid && n < 20);
      check("t2 zero valid", b_out_valid, 1'b1);
      check("t2 zero hi_sum", b_out_hi_sum, 3'd0);
      check("t2 zero lo_sum", b_out_lo_sum, 3'd0);
      check("t2 zero sat", b_out_sat, 1'b0);

      // T3: out_ready low, stream 4'h9; FIFO fills while holding
      a_out_ready = 1'b0; a_pushed = 0; a_target = 8; a_in_data = 4'h9; a_in_valid = 1'b1;
      repeat (8) tick();
      check("t3 hold valid", a_out_valid, 1'b1);
      check("t3 full in_ready", a_in_ready, 1'b0);
      check("t3 words accepted", a_pushed, 6);
      check("t3 hi_sum", a_out_hi_sum, 8'd8);
      check("t3 lo_sum", a_out_lo_sum, 8'd4);
      repeat (2) tick();
      check("t3 still valid", a_out_valid, 1'b1);
      check("t3 stable hi_sum", a_out_hi_sum, 8'd8);
      check("t3 stable lo_sum", a_out_lo_sum, 8'd4);
      a_out_ready = 1'b1;
      tick();
      check("t3 valid dropped", a_out_valid, 1'b0);
      check("t3 hi held", a_out_hi_sum, 8'd8);
      check("t3 no pop in resume", a_in_ready, 1'b0);
      tick();
      check("t3 first pop pending", a_in_ready, 1'b0);
      tick();
      check("t3 slot freed", a_in_ready, 1'b1);
      n = 0;
      do begin tick(); n++; end while (!a_out_valid && n < 20);
      check("t3 second valid", a_out_valid, 1'b1);
      check("t3 second hi_sum", a_out_hi_sum, 8'd8);
      check("t3 second lo_sum", a_out_lo_sum, 8'd4);

      // T4: alternating 4'h1/4'h4 with push and pop together at one entry
      tick();
      tick();
      a_pushed = 0; a_target = 4; a_in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a_in_data = (i % 2 == 1) ? 4'h4 : 4'h1;
         check($sformatf("t4 in_ready w%0d", i), a_in_ready, 1'b1);
         tick();
      end
      n = 0;
      do begin tick(); n++; end while (!a_out_valid && n < 20);
      check("t4 valid", a_out_valid, 1'b1);
      check("t4 hi_sum", a_out_hi_sum, 8'd2);
      check("t4 lo_sum", a_out_lo_sum, 8'd2);

      // T5: reset after two words of 4'h5, then a full frame of 4'hA
      a_pushed = 0; a_target = 2; a_in_data = 4'h5; a_in_valid = 1'b1;
      tick();
      tick();
      tick();
      a_rst_n = 1'b0;
      #1;
      check("t5 rst in_ready", a_in_ready, 1'b0);
      check("t5 rst out_valid", a_out_valid, 1'b0);
      check("t5 rst hi_sum", a_out_hi_sum, 8'd0);
      tick();
      tick();
      a_rst_n = 1'b1;
      a_pushed = 0; a_target = 4; a_in_data = 4'hA; a_in_valid = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!a_out_valid && n < 20);
      check("t5 valid", a_out_valid, 1'b1);
      check("t5 hi_sum", a_out_hi_sum, 8'd8);
      check("t5 lo_sum", a_out_lo_sum, 8'd8);
      check("t5 sat", a_out_sat, 1'b0);
      extra = 0;
      repeat (12) begin
         tick();
         if (a_out_valid) extra++;
      end
      check("t5 no extra result", extra, 0);

      // T6: FRAME_LEN=1 streaming 4'h6, one result every 3 cycles
      c_in_data = 4'h6; c_in_valid = 1'b1; c_out_ready = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         tick();
         check($sformatf("t6 out_valid c%0d", c), c_out_valid, (c % 3 == 2));
         if (c % 3 == 2) begin
            check($sformatf("t6 hi_sum c%0d", c), c_out_hi_sum, 8'd1);
            check($sformatf("t6 lo_sum c%0d", c), c_out_lo_sum, 8'd2);
         end
      end
      c_in_valid = 1'b0;
      tick();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
